// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
// Bundles the decode read port, the issue/scoreboard port and the writeback
// write port of the architectural register file into one interface.
//
// Signals:
//   rd_en, rs_addr, rt_addr   decode read request and source addresses
//   rs_data, rt_data          registered read data returned to decode
//   stall                     a requested source still has a write in flight
//   issue_en, issue_rd        decode issues an instruction writing issue_rd
//   wr_en, wr_addr, wr_data   writeback write (reg_wren / rd_out / writeBackData)
//   sb_overflow               sticky: an issue hit a saturated pending counter
//
// Modports:
//   master  decode + writeback side (drives requests, receives data/status)
//   slave   register file side
// -----------------------------------------------------------------------------
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              stall;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sb_overflow;

    modport master (
        output rd_en, rs_addr, rt_addr,
        output issue_en, issue_rd,
        output wr_en, wr_addr, wr_data,
        input  rs_data, rt_data, stall, sb_overflow
    );

    modport slave (
        input  rd_en, rs_addr, rt_addr,
        input  issue_en, issue_rd,
        input  wr_en, wr_addr, wr_data,
        output rs_data, rt_data, stall, sb_overflow
    );
endinterface

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// Architectural register file sitting at the consuming end of writeback.
// Two registered read ports feed decode; a per-register pending-write
// counter (scoreboard) raises stall while a requested source operand still
// has a write in flight. Register 0 reads as zero and is never written.
//
// Ports:
//   clk     single clock, rising edge
//   reset   asynchronous, active-high; clears registers, counters and outputs
//   bus     register_file_if.slave (read, issue and write ports, status)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read sampled on the same edge as a write to the same nonzero
//               register returns the write data, and the last pending write to
//               a register releases stall in its own cycle.
//   undefined : same-edge reads return the old value; stall releases one
//               cycle after the final write.
// -----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    register_file_if.slave    bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] r_regs [NREG];
    logic [CNT_W-1:0]  r_pend [NREG];
    logic [DATA_W-1:0] r_rsData;
    logic [DATA_W-1:0] r_rtData;
    logic              r_overflow;

    logic [NREG-1:0]   w_issueHit;
    logic [NREG-1:0]   w_writeHit;
    logic              w_rsRelease;
    logic              w_rtRelease;
    logic              w_rsForward;
    logic              w_rtForward;
    logic              w_rsBusy;
    logic              w_rtBusy;
    logic              w_stall;
    logic              w_overflowHit;
    logic [DATA_W-1:0] w_rsNext;
    logic [DATA_W-1:0] w_rtNext;

    // One-hot decode of which register is being issued to and which is being
    // written this cycle. Address 0 never sets a bit, which keeps pend[0]
    // pinned at zero without any special case in the counter update.
    always_comb begin
        w_issueHit = '0;
        w_writeHit = '0;
        if (bus.issue_en && (bus.issue_rd != '0)) begin
            w_issueHit[bus.issue_rd] = 1'b1;
        end
        if (bus.wr_en && (bus.wr_addr != '0)) begin
            w_writeHit[bus.wr_addr] = 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // The write landing this cycle is the last outstanding one for a source,
    // so that source is treated as ready now; its data is forwarded below.
    assign w_rsRelease = (r_pend[bus.rs_addr] == CNT_W'(1)) && bus.wr_en && (bus.wr_addr == bus.rs_addr);
    assign w_rtRelease = (r_pend[bus.rt_addr] == CNT_W'(1)) && bus.wr_en && (bus.wr_addr == bus.rt_addr);
    assign w_rsForward = bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == bus.rs_addr);
    assign w_rtForward = bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == bus.rt_addr);
`else
    assign w_rsRelease = 1'b0;
    assign w_rtRelease = 1'b0;
    assign w_rsForward = 1'b0;
    assign w_rtForward = 1'b0;
`endif

    // Stall uses counter values from the previous edge only; an issue in this
    // same cycle cannot raise it.
    assign w_rsBusy = (bus.rs_addr != '0) && (r_pend[bus.rs_addr] != '0) && !w_rsRelease;
    assign w_rtBusy = (bus.rt_addr != '0) && (r_pend[bus.rt_addr] != '0) && !w_rtRelease;
    assign w_stall  = bus.rd_en && (w_rsBusy || w_rtBusy);

    // Saturation: an issue to a full counter that is not simultaneously
    // cancelled by a write to the same register.
    assign w_overflowHit = bus.issue_en && (bus.issue_rd != '0) && !w_writeHit[bus.issue_rd]
                           && (r_pend[bus.issue_rd] == CNT_MAX);

    assign w_rsNext = (bus.rs_addr == '0) ? '0 : (w_rsForward ? bus.wr_data : r_regs[bus.rs_addr]);
    assign w_rtNext = (bus.rt_addr == '0) ? '0 : (w_rtForward ? bus.wr_data : r_regs[bus.rt_addr]);

    // Register array write port. Register 0 is never stored to so it stays 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != '0)) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Pending-write counters. An issue and a write to the same register in
    // one cycle cancel out. Increments saturate at the max value (flagging
    // overflow) and decrements at zero are dropped, which also absorbs the
    // writes still draining from before a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_pend[i] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_issueHit[i] && !w_writeHit[i]) begin
                    if (r_pend[i] != CNT_MAX) begin
                        r_pend[i] <= r_pend[i] + CNT_W'(1);
                    end
                end else if (w_writeHit[i] && !w_issueHit[i]) begin
                    if (r_pend[i] != '0) begin
                        r_pend[i] <= r_pend[i] - CNT_W'(1);
                    end
                end
            end
            if (w_overflowHit) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Registered read ports. A stalled or absent read leaves both outputs
    // holding their previous values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsData <= '0;
            r_rtData <= '0;
        end else if (bus.rd_en && !w_stall) begin
            r_rsData <= w_rsNext;
            r_rtData <= w_rtNext;
        end
    end

    assign bus.rs_data     = r_rsData;
    assign bus.rt_data     = r_rtData;
    assign bus.stall       = w_stall;
    assign bus.sb_overflow = r_overflow;
endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Scoreboard bench for register_file. Each stimulus cycle that should launch
// a read pushes its hand-computed read data into a queue; an independent
// monitor pops and compares whenever the DUT accepts a read. Stall and
// sb_overflow are compared directly against hand-computed values every cycle.
// Expectations follow REGFILE_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_register_file;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        string       name;
    } readExp_t;

    logic     clk;
    logic     reset;
    logic     fire;
    logic     tbExpOvf;
    int       checkCount;
    int       failCount;
    readExp_t expQueue [$];

    register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stops advancing.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then check the
    // combinational stall and the sticky overflow flag mid-cycle. A read that
    // should be accepted gets its expected data queued for the monitor.
    task automatic applyStimulus(
        input logic rdEn, input logic [4:0] rs, input logic [4:0] rt,
        input logic issEn, input logic [4:0] issRd,
        input logic wrEn, input logic [4:0] wrA, input logic [31:0] wrD,
        input logic expStall, input logic [31:0] expRs, input logic [31:0] expRt,
        input string name);
        readExp_t e;
        @(negedge clk);
        bus.rd_en    = rdEn;
        bus.rs_addr  = rs;
        bus.rt_addr  = rt;
        bus.issue_en = issEn;
        bus.issue_rd = issRd;
        bus.wr_en    = wrEn;
        bus.wr_addr  = wrA;
        bus.wr_data  = wrD;
        #2;
        checkOutput({name, "/stall"}, 32'(bus.stall), 32'(expStall));
        checkOutput({name, "/ovf"}, 32'(bus.sb_overflow), 32'(tbExpOvf));
        if (rdEn && !expStall) begin
            e.rs   = expRs;
            e.rt   = expRt;
            e.name = name;
            expQueue.push_back(e);
        end
    endtask

    task automatic idleCycle(input string name);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, name);
    endtask

    // Monitor: a read is accepted at a rising edge when rd_en is high and
    // stall is low just before it; the registered data is compared shortly
    // after that edge against the oldest queued expectation.
    initial begin
        readExp_t e;
        forever begin
            @(negedge clk);
            #4;
            fire = bus.rd_en && !bus.stall && !reset;
            @(posedge clk);
            #1;
            if (fire) begin
                if (expQueue.size() == 0) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL unexpectedRead: got rs=%h rt=%h required no read", bus.rs_data, bus.rt_data);
                end else begin
                    e = expQueue.pop_front();
                    checkOutput({e.name, "/rs_data"}, bus.rs_data, e.rs);
                    checkOutput({e.name, "/rt_data"}, bus.rt_data, e.rt);
                end
            end
        end
    end

    initial begin
        checkCount   = 0;
        failCount    = 0;
        tbExpOvf     = 1'b0;
        fire         = 1'b0;
        reset        = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rs_addr  = '0;
        bus.rt_addr  = '0;
        bus.issue_en = 1'b0;
        bus.issue_rd = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        #1 reset = 1'b1;
        #1;
        checkOutput("init/rs_data", bus.rs_data, 32'h0);
        checkOutput("init/rt_data", bus.rt_data, 32'h0);
        checkOutput("init/stall", 32'(bus.stall), 32'h0);
        checkOutput("init/ovf", 32'(bus.sb_overflow), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write / read-back, including writes to r0 being dropped.
        applyStimulus(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, "wrR5");
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 32'h0, 0, 32'hDEADBEEF, 32'h0, "rdR5");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, "wrR0");
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'hDEADBEEF, "rdR0");
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hA5A50001, 0, 0, 0, "wrR1");
        applyStimulus(0, 0, 0, 1, 2, 0, 0, 32'h0, 0, 0, 0, "issR2");
        idleCycle("idleA");
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 32'h0, 0, 32'hDEADBEEF, 32'hA5A50001, "rdR5R1");

        // Asynchronous reset mid-cycle, with r2 pending and a read of r2
        // requested: outputs and stall must clear without waiting for an edge.
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rs_addr = 5'd2;
        bus.rt_addr = 5'd5;
        #2;
        checkOutput("preReset/stall", 32'(bus.stall), 32'h1);
        #1 reset = 1'b1;
        #1;
        checkOutput("asyncReset/rs_data", bus.rs_data, 32'h0);
        checkOutput("asyncReset/rt_data", bus.rt_data, 32'h0);
        checkOutput("asyncReset/stall", 32'(bus.stall), 32'h0);
        checkOutput("asyncReset/ovf", 32'(bus.sb_overflow), 32'h0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        reset     = 1'b0;

        // Every register reads back as zero after reset.
        for (int r = 1; r < 32; r++) begin
            applyStimulus(1, 5'(r), 5'(32 - r), 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, $sformatf("rst%0d", r));
        end

        // A write draining after reset must not push pend[2] below zero.
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 32'h22, 0, 0, 0, "lateWrR2");
        applyStimulus(0, 0, 0, 1, 2, 0, 0, 32'h0, 0, 0, 0, "issR2b");
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, "stallR2");
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 32'h23, 0, 0, 0, "wrR2");
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 32'h0, 0, 32'h23, 32'h0, "rdR2");

        // Single hazard on r7 resolved by its write.
        applyStimulus(0, 0, 0, 1, 7, 0, 0, 32'h0, 0, 0, 0, "issR7");
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 32'h0, 1, 0, 0, "stallR7");
        applyStimulus(1, 0, 7, 0, 0, 1, 7, 32'h55, !BYP, 32'h0, 32'h55, "wrR7");
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h55, "rdR7");

        // Two writes in flight on r3; only the second write frees it.
        applyStimulus(0, 0, 0, 1, 3, 0, 0, 32'h0, 0, 0, 0, "issR3a");
        applyStimulus(0, 3, 0, 1, 3, 0, 0, 32'h0, 0, 0, 0, "issR3b");
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, "stallR3a");
        applyStimulus(1, 3, 0, 0, 0, 1, 3, 32'h33, 1, 0, 0, "wrR3a");
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, "stallR3b");
        applyStimulus(1, 3, 0, 0, 0, 1, 3, 32'h44, !BYP, 32'h44, 32'h0, "wrR3b");
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 32'h0, 0, 32'h44, 32'h0, "rdR3");

        // Issue and write to r9 in one cycle leave pend[9] at 1.
        applyStimulus(0, 0, 0, 1, 9, 0, 0, 32'h0, 0, 0, 0, "issR9");
        applyStimulus(0, 0, 0, 1, 9, 1, 9, 32'h99, 0, 0, 0, "issWrR9");
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, "stallR9");
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 32'h77, 0, 0, 0, "wrR9");
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 32'h0, 0, 32'h77, 32'h0, "rdR9");

        // Four issues to r4 saturate its counter at 3 and set overflow;
        // three writes then drain it while overflow stays set.
        applyStimulus(0, 0, 0, 1, 4, 0, 0, 32'h0, 0, 0, 0, "issR4a");
        applyStimulus(0, 0, 0, 1, 4, 0, 0, 32'h0, 0, 0, 0, "issR4b");
        applyStimulus(0, 0, 0, 1, 4, 0, 0, 32'h0, 0, 0, 0, "issR4c");
        applyStimulus(0, 0, 0, 1, 4, 0, 0, 32'h0, 0, 0, 0, "issR4d");
        tbExpOvf = 1'b1;
        applyStimulus(1, 4, 4, 0, 0, 0, 0, 32'h0, 1, 0, 0, "stallR4");
        applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'h41, 0, 0, 0, "wrR4a");
        applyStimulus(1, 0, 4, 0, 0, 1, 4, 32'h42, 1, 0, 0, "wrR4b");
        applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'h43, 0, 0, 0, "wrR4c");
        applyStimulus(1, 4, 4, 0, 0, 0, 0, 32'h0, 0, 32'h43, 32'h43, "rdR4");

        idleCycle("drainA");
        idleCycle("drainB");
        checkOutput("queueDrained", 32'(expQueue.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/register_file.md
# register_file

Architectural register file at the consuming end of the writeback interface. It accepts `reg_wren`/`rd_out`/`writeBackData` from the writeback stage, serves two registered read ports to decode, and keeps a per-register pending-write scoreboard that raises `stall` while a source operand still has a write in flight. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width; `2**ADDR_W` registers
- `CNT_W`, 2, scoreboard counter width per register; max in-flight writes per register is `2**CNT_W - 1`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `rd_en`  in  1  decode read request this cycle
- `rs_addr`  in  ADDR_W  source register A
- `rt_addr`  in  ADDR_W  source register B
- `rs_data`  out  DATA_W  registered read data A
- `rt_data`  out  DATA_W  registered read data B
- `stall`  out  1  combinational; a requested source has a pending write
- `issue_en`  in  1  decode issues an instruction that will write `issue_rd`
- `issue_rd`  in  ADDR_W  destination of the issued instruction
- `wr_en`  in  1  write enable from writeback (`reg_wren`)
- `wr_addr`  in  ADDR_W  write destination (`rd_out`)
- `wr_data`  in  DATA_W  write data (`writeBackData`)
- `sb_overflow`  out  1  sticky flag; an issue hit a saturated counter

## Operation
- Write: on a rising edge with `wr_en=1` and `wr_addr!=0`, `regs[wr_addr] <= wr_data`. Writes to register 0 are discarded.
- Read: on a rising edge with `rd_en=1 && stall=0`, `rs_data <= regs[rs_addr]` and `rt_data <= regs[rt_addr]`. Address 0 always returns 0. Otherwise both outputs hold.
- Scoreboard: one counter `pend[r]` per register; `pend[0]` is held at 0.
  - Issue only (`issue_en`, `issue_rd!=0`): increment.
  - Write only (`wr_en`, `wr_addr!=0`): decrement. A decrement at 0 is ignored.
  - Issue and write to the same register in the same cycle: counter unchanged.
  - Issue to a counter at max (3): counter stays at 3 and `sb_overflow` sets. It clears only on reset.
- Stall:
  - `stall = rd_en && (busy(rs_addr) || busy(rt_addr))`.
  - `busy(r) = (r!=0) && pend[r]!=0`, modified by the bypass rule in Configuration.
  - `issue_en` in the same cycle does not affect `stall`, because the counter updates at the edge.
- Decode must not assert `issue_en` while `stall=1`. The block does not gate it.

## Timing
- Read latency is 1 cycle: data appears after the edge that samples `rd_en`.
- A write is visible to reads sampled on the next edge. Same-edge visibility is covered by Configuration.
- Scoreboard updates and `sb_overflow` take effect at the edge. `stall` reflects counters after the previous edge.
- Reset values: all `regs`=0, all `pend`=0, `rs_data`=0, `rt_data`=0, `sb_overflow`=0.
- `stall`=0 while `reset` is asserted, because all counters are 0.
- Reset mid-operation discards in-flight scoreboard state. Writes arriving after reset deassertion decrement from 0 and are ignored.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read sampled on the same edge as a write to the same nonzero address returns `wr_data`, with per-port compare on `rs` and `rt`.
  - `busy(r)` is false when `pend[r]==1 && wr_en && wr_addr==r`, so the final pending write releases the stall in its own cycle.
- `REGFILE_BYPASS_EN` not defined:
  - A same-edge read returns the old register value.
  - `busy(r)` ignores the current write, so the stall releases one cycle later.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> `rs_data`/`rt_data`=0, `stall`=0, `sb_overflow`=0 immediately. Then read r1..r31 -> all 0.
- Write and read back:
  - Write 0xDEADBEEF to r5; next cycle read `rs_addr`=5 -> `rs_data`=0xDEADBEEF one cycle later.
  - Write 0x1234 to r0, then read r0 -> `rs_data`=0.
- Hazard:
  - `issue_en` with `issue_rd`=7; next cycle `rd_en` with `rt_addr`=7 -> `stall`=1.
  - Write r7=0x55 ->
    - with `REGFILE_BYPASS_EN`: `stall`=0 that cycle, and `rt_data`=0x55 after the edge.
    - without it: `stall` drops one cycle later, then `rt_data`=0x55.
- Multiple in flight: issue r3 twice, then one write to r3 -> `stall` stays 1 on r3. The second write clears it.
- Simultaneous issue and write to r9 at `pend`=1 -> `pend` stays 1 and `stall` on r9 stays 1.
- Overflow: issue r4 four times with no writes -> `sb_overflow`=1 after the fourth edge and `pend[4]`=3. Three writes to r4 -> `stall` clears while `sb_overflow` stays 1.
